// File: rtl/vga_capture.sv
// Captures a VGA-style RGB888 stream, checks its geometry and writes a 4x4-decimated
// RGB332 image into a 160x100 VRAM using the 14-bit word write port.
module vga_capture #(
   parameter int unsigned H    = 640,
   parameter int unsigned V    = 400,
   parameter int unsigned XDIV = 4,
   parameter int unsigned YDIV = 4,
   parameter int unsigned OW   = H / XDIV
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        enable,
   input  logic        hs,
   input  logic        vs,
   input  logic        de,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        wr,
   output logic [13:0] addr,
   output logic [7:0]  data,
   output logic        frame_done,
   output logic        locked,
   output logic        err,
   output logic [9:0]  h_total
);

   localparam int unsigned CW = 10;
   localparam int unsigned AW = 14;
   localparam int unsigned DW = 8;
   localparam logic [CW-1:0] H_C    = CW'(H);
   localparam logic [CW-1:0] V_C    = CW'(V);
   localparam logic [CW-1:0] XMASK  = CW'(XDIV - 1);
   localparam logic [CW-1:0] YMASK  = CW'(YDIV - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // Stage 1: input registers plus one delayed copy of the sync/enable lines
   logic          hs_q, vs_q, de_q;
   logic          hs_dly_q, vs_dly_q, de_dly_q;
   logic [DW-1:0] rgb_q;

   state_t        state_q, state_d;
   logic [CW-1:0] x_cnt_q, x_cnt_d;
   logic [CW-1:0] y_cnt_q, y_cnt_d;
   logic [CW-1:0] hs_cnt_q, hs_cnt_d;
   logic [CW-1:0] h_total_q, h_total_d;
   logic [1:0]    good_cnt_q, good_cnt_d;
   logic          line_bad_q, line_bad_d;
   logic          locked_q, locked_d;
   logic          err_q, err_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          frame_done_q, frame_done_d;

   logic          vs_rise_c, de_rise_c, de_fall_c, hs_fall_c;
   logic [CW-1:0] x_idx_c;
   logic          pix_c, in_area_c, grid_c, cap_c, frame_good_c;
   logic [AW-1:0] addr_c;
   logic          unused_c;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   // Only the RGB332 bits are kept
   assign unused_c = ^{r[4:0], g[4:0], b[5:0]};

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         de_q     <= 1'b0;
         hs_dly_q <= 1'b0;
         vs_dly_q <= 1'b0;
         de_dly_q <= 1'b0;
         rgb_q    <= '0;
      end else begin
         hs_q     <= hs;
         vs_q     <= vs;
         de_q     <= de;
         hs_dly_q <= hs_q;
         vs_dly_q <= vs_q;
         de_dly_q <= de_q;
         rgb_q    <= {r[7:5], g[7:5], b[7:6]};
      end
   end

   assign vs_rise_c = vs_q & ~vs_dly_q;
   assign de_rise_c = de_q & ~de_dly_q;
   assign de_fall_c = ~de_q & de_dly_q;
   assign hs_fall_c = ~hs_q & hs_dly_q;

   // Index of the pixel now in stage 1; x_cnt_q already counts earlier pixels of the line
   assign x_idx_c      = de_rise_c ? '0 : x_cnt_q;
   assign pix_c        = de_q & ~vs_rise_c;
   assign in_area_c    = (x_idx_c < H_C) && (y_cnt_q < V_C);
   assign grid_c       = ((x_idx_c & XMASK) == '0) && ((y_cnt_q & YMASK) == '0);
   assign cap_c        = (state_q == CAPTURE) && enable;
   assign frame_good_c = (y_cnt_q == V_C) && !line_bad_q && !de_q;
   assign addr_c       = AW'((32'(y_cnt_q) / YDIV) * OW + 32'(x_idx_c) / XDIV);

   always_comb begin
      state_d      = state_q;
      x_cnt_d      = x_cnt_q;
      y_cnt_d      = y_cnt_q;
      hs_cnt_d     = sat_inc(hs_cnt_q);
      h_total_d    = h_total_q;
      good_cnt_d   = good_cnt_q;
      line_bad_d   = line_bad_q;
      locked_d     = locked_q;
      err_d        = err_q;
      wr_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      frame_done_d = 1'b0;

      if (de_q) begin
         x_cnt_d = de_rise_c ? CW'(1) : sat_inc(x_cnt_q);
      end

      if (vs_rise_c) begin
         y_cnt_d = '0;
      end else if (de_fall_c) begin
         y_cnt_d = sat_inc(y_cnt_q);
      end

      if (hs_fall_c) begin
         h_total_d = sat_inc(hs_cnt_q);
         hs_cnt_d  = '0;
      end

      if (de_fall_c && (x_cnt_q != H_C)) begin
         line_bad_d = 1'b1;
      end

      // Frame qualification and lock tracking at every frame boundary
      if (vs_rise_c) begin
         line_bad_d = 1'b0;
         if (frame_good_c) begin
            good_cnt_d = (good_cnt_q == 2'd2) ? 2'd2 : good_cnt_q + 2'd1;
            locked_d   = (good_cnt_d == 2'd2);
         end else begin
            good_cnt_d = '0;
            locked_d   = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_VS;
         end
         WAIT_VS: begin
            if (vs_rise_c) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (vs_rise_c) frame_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (!enable) begin
         state_d      = IDLE;
         frame_done_d = 1'b0;
      end

      if (state_q == IDLE) begin
         err_d = 1'b0;
      end else if (cap_c && ((pix_c && !in_area_c) ||
                             (de_fall_c && (x_cnt_q < H_C)) ||
                             (vs_rise_c && (y_cnt_q < V_C)))) begin
         err_d = 1'b1;
      end

      if (cap_c && pix_c && in_area_c && grid_c) begin
         wr_d   = 1'b1;
         addr_d = addr_c;
         data_d = rgb_q;
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         hs_cnt_q     <= '0;
         h_total_q    <= '0;
         good_cnt_q   <= '0;
         line_bad_q   <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_cnt_q      <= x_cnt_d;
         y_cnt_q      <= y_cnt_d;
         hs_cnt_q     <= hs_cnt_d;
         h_total_q    <= h_total_d;
         good_cnt_q   <= good_cnt_d;
         line_bad_q   <= line_bad_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr         = wr_q;
   assign addr       = addr_q;
   assign data       = data_q;
   assign frame_done = frame_done_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign h_total    = h_total_q;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Video-input counterpart of the 160x100 VRAM display path. Receives a 640x400 VGA-style stream (hs, vs, de, 24-bit RGB) on the pixel clock.
- Checks frame geometry and decimates 4x4 by taking the top-left pixel of each block. Converts RGB888 to RGB332.
- Emits write strobes in the existing 14-bit VRAM write format, so a captured frame can be loaded into a 160x100 framebuffer.

Parameters:
H, 640, active pixels per line (de-high pclk cycles)
V, 400, active lines per frame
XDIV, 4, horizontal decimation factor (power of two)
YDIV, 4, vertical decimation factor (power of two)
OW, 160, output words per line (H/XDIV)

Ports:
pclk  input  1  pixel clock; the only clock
reset  input  1  asynchronous, active-high reset
enable  input  1  capture enable
hs  input  1  hsync, active low
vs  input  1  vsync, active high
de  input  1  data enable, high in active area
r  input  8  red
g  input  8  green
b  input  8  blue
wr  output  1  VRAM write strobe, one cycle per word
addr  output  14  VRAM word address
data  output  8  RGB332 word {r[7:5],g[7:5],b[7:6]}
frame_done  output  1  one-cycle pulse: a captured frame finished
locked  output  1  input geometry stable
err  output  1  sticky geometry error
h_total  output  10  pclk cycles between the last two hs falling edges

Behaviour:
- Reset values while reset=1: wr=0, addr=0, data=0, frame_done=0, locked=0, err=0, h_total=0, state=IDLE, and all counters 0.
- Stage 1 registers hs, vs, de and rgb, plus one delayed copy of hs, vs and de. Edges are detected from registered versus delayed values.
- Stage 2 registers wr, addr and data. A pixel present on the inputs at edge N produces wr at edge N+2 (latency 2).
- x_cnt counts stage-1 de-high cycles. It clears on de rise and saturates at 1023.
- y_cnt increments on de fall, clears on vs rise, and saturates at 1023.
- An hs counter runs freely. On hs fall, h_total <= count+1 (saturating at 1023) and the counter restarts at 0.
- A line is good if x_cnt==H at de fall. A frame is good if y_cnt==V at vs rise and every line in it was good.
- Good-frame counter: 2 consecutive good frames set locked=1. A bad frame clears locked and the counter in the same cycle as the vs rise.
- States:
  - IDLE: wr=0. Go to WAIT_VS when enable=1.
  - WAIT_VS: go to CAPTURE on vs rise.
  - CAPTURE: write pixels. On each vs rise, pulse frame_done=1 for one cycle and stay in CAPTURE.
  - From any state, enable=0 forces IDLE on the next edge. No wr is issued after that edge and frame_done is not pulsed.
- Write rule, in CAPTURE with de=1 and (x_cnt<H and y_cnt<V):
  - Condition: x_cnt mod XDIV==0 and y_cnt mod YDIV==0, where x_cnt is the index of the current pixel, starting at 0.
  - addr = (y_cnt/YDIV)*OW + x_cnt/XDIV, truncated to 14 bits. data = RGB332 of the pixel.
- A nominal frame yields exactly 16000 writes, addresses 0..15999 in increasing order.
- Overruns: pixels with x_cnt>=H or lines with y_cnt>=V are not written. They set err=1.
- err is also set by a short line or a short frame while in CAPTURE. err clears only on reset or in IDLE.
- enable asserted mid-frame: capture begins at the next vs rise. The partial frame is never written.
- Reset mid-frame: everything returns to reset values immediately. After release, the lock sequence restarts from 0.
- vs rise coinciding with de=1: the edge takes priority, so y_cnt clears and the frame is counted bad.

Test Plan:
- Reset asserted mid-frame with wr active -> wr=0, addr=0, locked=0, err=0 in the same cycle, with no pclk edge needed. After release, two good frames are needed before locked=1.
- enable=1, then 3 nominal frames whose pixel value is {r=x, g=y, b=0} (low 8 bits) -> exactly 16000 writes per captured frame, addr 0..15999 ascending.
  - Pixel (x=4,y=4) -> addr=161, data={r[7:5]=0,g[7:5]=0,b=0}=8'h00.
  - Pixel (x=636,y=396) -> addr=15999.
- Solid r=8'hE0, g=8'h1C, b=8'hC0 frame -> every write has data=8'hE3. frame_done pulses once per vs rise in CAPTURE. Check wr at input edge+2.
- One line with 639 de cycles inside a locked stream -> err=1, locked=0 at that frame's vs rise. locked returns after 2 further good frames, while err stays 1.
- enable dropped at line 200 -> no wr after the following edge, no frame_done. State returns to IDLE.
- 800-cycle hs period -> h_total=800 after the second hs fall. A 402-line frame -> err=1, no writes for y>=400.
